i2c_slave: RTL

- Single-address I2C target; the bus counterpart of i2c_master, on the same open-drain scl/sda pair.
- Oversamples scl/sda in the system clock domain and detects START, repeated START and STOP.
- Matches a 7-bit address, accepts write bytes toward the fabric, and serves read bytes from the fabric.
- No clock stretching: scl is input only.

---
 rtl/i2c_slave.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave.sv
// Single-address I2C target without clock stretching: synchronises and glitch-filters
// scl/sda, tracks START/STOP, and moves bytes between the bus and the fabric.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h03,
    parameter int         FILT       = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] data_tx,
    output logic       tx_load,
    output logic [7:0] data_rx,
    output logic       rx_valid,
    output logic       busy
);

    localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, IGNORE
    } state_t;

    logic          scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
    logic          sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
    logic [CW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic          scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic          scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          rw_q, rw_d;
    logic          ack_q, ack_d;
    logic          oe_q, oe_d;
    logic          busy_q, busy_d;
    logic [7:0]    data_rx_q, data_rx_d;
    logic          rx_valid_q, rx_valid_d;
    logic          tx_load_q, tx_load_d;

    logic          start_ev, stop_ev, scl_rise, scl_fall;

    assign sda      = oe_q ? 1'b0 : 1'bz;
    assign tx_load  = tx_load_q;
    assign data_rx  = data_rx_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;

    always_comb begin
        scl_s1_d   = scl;
        scl_s2_d   = scl_s1_q;
        sda_s1_d   = sda;
        sda_s2_d   = sda_s1_q;
        scl_prev_d = scl_f_q;
        sda_prev_d = sda_f_q;

        // A filtered line flips only once FILT consecutive samples disagree with it.
        scl_f_d   = scl_f_q;
        scl_cnt_d = '0;
        if (scl_s2_q != scl_f_q) begin
            if (scl_cnt_q == CW'(FILT - 1)) scl_f_d = scl_s2_q;
            else                            scl_cnt_d = scl_cnt_q + CW'(1);
        end
        sda_f_d   = sda_f_q;
        sda_cnt_d = '0;
        if (sda_s2_q != sda_f_q) begin
            if (sda_cnt_q == CW'(FILT - 1)) sda_f_d = sda_s2_q;
            else                            sda_cnt_d = sda_cnt_q + CW'(1);
        end

        start_ev = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
        stop_ev  = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;
        scl_rise = scl_f_q & ~scl_prev_q;
        scl_fall = ~scl_f_q & scl_prev_q;

        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rw_d       = rw_q;
        ack_d      = ack_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        data_rx_d  = data_rx_q;
        rx_valid_d = 1'b0;
        tx_load_d  = 1'b0;

        if (stop_ev) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start_ev) begin
            state_d = ADDR;
            oe_d    = 1'b0;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_f_q};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            oe_d    = 1'b1;
                            busy_d  = 1'b1;
                            rw_d    = shift_q[0];
                            state_d = ADDR_ACK;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!rw_q) begin
                            oe_d    = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = WRITE;
                        end else begin
                            tx_load_d = 1'b1;
                            shift_d   = data_tx;
                            oe_d      = ~data_tx[7];
                            cnt_d     = 4'd1;
                            state_d   = READ;
                        end
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_f_q};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        data_rx_d  = shift_q;
                        rx_valid_d = 1'b1;
                        oe_d       = 1'b1;
                        state_d    = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = WRITE;
                    end
                end
                READ: begin
                    // cnt counts bits already presented; bit 7 went out with the load.
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            state_d = RD_ACK;
                        end else begin
                            oe_d    = ~shift_q[6];
                            shift_d = {shift_q[6:0], 1'b0};
                            cnt_d   = cnt_q + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        ack_d = sda_f_q;
                    end else if (scl_fall) begin
                        if (!ack_q) begin
                            tx_load_d = 1'b1;
                            shift_d   = data_tx;
                            oe_d      = ~data_tx[7];
                            cnt_d     = 4'd1;
                            state_d   = READ;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'h00;
            rw_q       <= 1'b0;
            ack_q      <= 1'b1;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            data_rx_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_load_q  <= 1'b0;
        end else begin
            scl_s1_q   <= scl_s1_d;
            scl_s2_q   <= scl_s2_d;
            sda_s1_q   <= sda_s1_d;
            sda_s2_q   <= sda_s2_d;
            scl_cnt_q  <= scl_cnt_d;
            sda_cnt_q  <= sda_cnt_d;
            scl_f_q    <= scl_f_d;
            sda_f_q    <= sda_f_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            data_rx_q  <= data_rx_d;
            rx_valid_q <= rx_valid_d;
            tx_load_q  <= tx_load_d;
        end
    end

endmodule
